// File: rtl/icache_refill_unit_pkg.sv
// Shared icache defines: geometry, address field locations and refill FSM encoding.
package icache_refill_unit_pkg;

  localparam int unsigned INDEX_SIZE = 8;
  localparam int unsigned TAG_SIZE   = 20;
  localparam int unsigned BANK_NUM   = 8;
  localparam int unsigned BANK_SIZE  = 32;

  localparam int unsigned LINE_W     = BANK_NUM * BANK_SIZE;
  localparam int unsigned WSEL_W     = $clog2(BANK_NUM);

  // Address field locations within the 32-bit instruction address
  localparam int unsigned TAG_LSB    = 12;
  localparam int unsigned INDEX_LSB  = 4;
  localparam int unsigned WORD_LSB   = 2;
  localparam int unsigned LINE_OFF_W = 5;
  localparam int unsigned TAGV_PAD   = 32 - 1 - TAG_SIZE;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_REQ   = 4'b0010,
    S_RECV  = 4'b0100,
    S_WRITE = 4'b1000
  } refill_state_e;

endpackage

// File: rtl/icache_line_buffer.sv
// Line assembly buffer: one word written per beat, full line and one selected word readable.
module icache_line_buffer
  import icache_refill_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [WSEL_W-1:0]    waddr_i,
  input  logic [BANK_SIZE-1:0] wdata_i,
  input  logic [WSEL_W-1:0]    raddr_i,
  output logic [LINE_W-1:0]    line_o,
  output logic [BANK_SIZE-1:0] rdata_o
);

  logic [BANK_SIZE-1:0] mem_q [BANK_NUM];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    line_o = '0;
    for (int unsigned k = 0; k < BANK_NUM; k++) begin
      line_o[k*BANK_SIZE +: BANK_SIZE] = mem_q[k];
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/icache_refill_unit.sv
// Icache miss refill: burst-read one line, write data banks and tag/valid together, return the missed word.
module icache_refill_unit
  import icache_refill_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  miss_valid,
  input  logic [31:0]           miss_addr,
  output logic                  miss_ready,
  input  logic                  cpu_cancel,
  output logic                  mem_req_valid,
  output logic [31:0]           mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rlast,
  output logic [BANK_NUM-1:0]   ram_we,
  output logic [INDEX_SIZE-1:0] ram_waddr,
  output logic [LINE_W-1:0]     ram_wdata,
  output logic                  tagv_we,
  output logic [31:0]           tagv_wdata,
  output logic                  cpu_inst_valid,
  output logic [31:0]           cpu_inst,
  output logic                  refill_busy,
  output logic                  protocol_err
);

  refill_state_e     state_q, state_d;
  logic [WSEL_W-1:0] cnt_q, cnt_d;
  logic              cancel_q, cancel_d;
  logic              perr_q, perr_d;
  logic [31:0]       addr_q, addr_d;
  logic              buf_we;
  logic [LINE_W-1:0] line;
  logic [31:0]       word;
  logic              last_beat;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^addr_q[1:0];
  assign last_beat        = (cnt_q == WSEL_W'(BANK_NUM - 1));

  icache_line_buffer u_line_buffer (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (cnt_q),
    .wdata_i (mem_rdata),
    .raddr_i (addr_q[WORD_LSB +: WSEL_W]),
    .line_o  (line),
    .rdata_o (word)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cancel_d = cancel_q;
    perr_d   = perr_q;
    addr_d   = addr_q;
    buf_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cancel_d = 1'b0;
        if (miss_valid) begin
          addr_d  = miss_addr;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (cpu_cancel) cancel_d = 1'b1;
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (cpu_cancel) cancel_d = 1'b1;
        if (mem_rvalid) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + WSEL_W'(1);
          // rlast is only audited; the beat counter alone ends the burst
          if (last_beat != mem_rlast) perr_d = 1'b1;
          if (last_beat) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        cancel_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cancel_q <= 1'b0;
      perr_q   <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cancel_q <= cancel_d;
      perr_q   <= perr_d;
      addr_q   <= addr_d;
    end
  end

  assign miss_ready    = (state_q == S_IDLE);
  assign refill_busy   = (state_q != S_IDLE);
  assign protocol_err  = perr_q;
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = (state_q == S_REQ) ? {addr_q[31:LINE_OFF_W], {LINE_OFF_W{1'b0}}} : '0;

  assign ram_we     = (state_q == S_WRITE) ? '1 : '0;
  assign ram_waddr  = (state_q == S_WRITE) ? addr_q[INDEX_LSB +: INDEX_SIZE] : '0;
  assign ram_wdata  = (state_q == S_WRITE) ? line : '0;
  assign tagv_we    = (state_q == S_WRITE);
  assign tagv_wdata = (state_q == S_WRITE) ?
                      {1'b1, addr_q[TAG_LSB +: TAG_SIZE], {TAGV_PAD{1'b0}}} : '0;
  assign cpu_inst   = (state_q == S_WRITE) ? word : '0;
  // A flush arriving in the WRITE cycle itself must also hold back delivery
  assign cpu_inst_valid = (state_q == S_WRITE) && !cancel_q && !cpu_cancel;

endmodule

// File: tb/tb_icache_refill_unit.sv
// Scoreboarded random bench for icache_refill_unit with an address/line reference model.
module tb_icache_refill_unit;

  logic         clk = 1'b0;
  logic         reset, miss_valid, cpu_cancel, mem_req_ready, mem_rvalid, mem_rlast;
  logic [31:0]  miss_addr, mem_rdata;
  logic         miss_ready, mem_req_valid, tagv_we, cpu_inst_valid, refill_busy, protocol_err;
  logic [31:0]  mem_req_addr, tagv_wdata, cpu_inst;
  logic [7:0]   ram_we, ram_waddr;
  logic [255:0] ram_wdata;

  always #5 clk = ~clk;

  icache_refill_unit dut (
    .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_addr(miss_addr),
    .miss_ready(miss_ready), .cpu_cancel(cpu_cancel), .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_rlast(mem_rlast), .ram_we(ram_we), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .tagv_we(tagv_we), .tagv_wdata(tagv_wdata),
    .cpu_inst_valid(cpu_inst_valid), .cpu_inst(cpu_inst), .refill_busy(refill_busy),
    .protocol_err(protocol_err)
  );

  typedef struct {
    logic [7:0]   idx;
    logic [255:0] line;
    logic [31:0]  tagv;
    logic [31:0]  inst;
    logic         valid;
    int unsigned  cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  logic [31:0] beats[8];
  logic        err_exp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: any write/delivery activity must match the oldest expected refill
  always @(negedge clk) begin
    if (ram_we != 8'h00 || tagv_we || cpu_inst_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got ram_we=%0h tagv_we=%0b inst_valid=%0b expected no activity",
                 ram_we, tagv_we, cpu_inst_valid);
      end else begin
        mon_e = sb.pop_front();
        chk("ram_we",         ram_we, 8'hFF);
        chk("ram_waddr",      ram_waddr, mon_e.idx);
        chk("ram_wdata",      ram_wdata, mon_e.line);
        chk("tagv_we",        tagv_we, 1'b1);
        chk("tagv_wdata",     tagv_wdata, mon_e.tagv);
        chk("cpu_inst",       cpu_inst, mon_e.inst);
        chk("cpu_inst_valid", cpu_inst_valid, mon_e.valid);
        chk("write_cycle",    cyc, mon_e.cyc);
        chk("busy_in_write",  refill_busy, 1'b1);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; miss_valid = 1'b0; cpu_cancel = 1'b0; mem_req_ready = 1'b0;
    mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rdata = '0; miss_addr = '0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    err_exp = 1'b0;
    chk("rst_miss_ready",   miss_ready, 1'b1);
    chk("rst_busy",         refill_busy, 1'b0);
    chk("rst_req_valid",    mem_req_valid, 1'b0);
    chk("rst_ram_we",       ram_we, 8'h00);
    chk("rst_tagv_we",      tagv_we, 1'b0);
    chk("rst_inst_valid",   cpu_inst_valid, 1'b0);
    chk("rst_protocol_err", protocol_err, 1'b0);
  endtask

  // One refill as seen from the bus side. bad_beat inverts rlast on that beat,
  // abort_after asserts reset after that beat, hold_next keeps miss_valid up with next_addr.
  task automatic refill(input logic [31:0] addr, input int w, input logic [7:0] gaps,
                        input int cancel_beat, input int bad_beat, input int abort_after,
                        input logic hold_next, input logic [31:0] next_addr);
    int unsigned p;
    int          n;
    exp_t        e;
    logic [31:0] tag;
    n = 0;
    while (!miss_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!miss_ready) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got miss_ready=0 expected 1 within 50 cycles");
      return;
    end
    miss_addr = addr; miss_valid = 1'b1;
    @(posedge clk); #1;
    p = cyc;
    miss_valid = hold_next;
    miss_addr  = hold_next ? next_addr : $urandom;
    if (abort_after < 0) begin
      tag    = addr >> 12;
      e.idx  = 8'((addr >> 4) & 32'hFF);
      e.tagv = 32'h8000_0000 | (tag << 11);
      e.inst = beats[(addr >> 2) & 32'h7];
      e.line = '0;
      for (int k = 0; k < 8; k++) e.line = e.line | (256'(beats[k]) << (32 * k));
      e.valid = (cancel_beat < 0);
      e.cyc   = p + 9 + w + $countones(gaps);
      sb.push_back(e);
    end
    for (int i = 0; i <= w; i++) begin
      mem_req_ready = (i == w);
      mem_rvalid = 1'($urandom); mem_rdata = $urandom; mem_rlast = 1'($urandom);
      chk("req_valid",       mem_req_valid, 1'b1);
      chk("req_addr",        mem_req_addr, addr & 32'hFFFF_FFE0);
      chk("miss_ready_busy", miss_ready, 1'b0);
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (gaps[k]) begin
        mem_rvalid = 1'b0; mem_rdata = $urandom; mem_rlast = 1'b0;
        chk("recv_no_req", mem_req_valid, 1'b0);
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b1; mem_rdata = beats[k];
      mem_rlast  = (k == 7) ^ (k == bad_beat);
      cpu_cancel = (k == cancel_beat);
      if (k == bad_beat) err_exp = 1'b1;
      chk("recv_busy", refill_busy, 1'b1);
      @(posedge clk); #1;
      cpu_cancel = 1'b0;
      if (k == abort_after) begin
        mem_rvalid = 1'b0; mem_rlast = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; err_exp = 1'b0;
        chk("abort_miss_ready", miss_ready, 1'b1);
        chk("abort_busy",       refill_busy, 1'b0);
        chk("abort_perr",       protocol_err, 1'b0);
        return;
      end
    end
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    chk("protocol_err", protocol_err, err_exp);
    @(posedge clk); #1;
    chk("miss_ready_after", miss_ready, 1'b1);
    chk("idle_busy",        refill_busy, 1'b0);
  endtask

  task automatic rand_beats();
    for (int k = 0; k < 8; k++) beats[k] = $urandom;
  endtask

  initial begin
    do_reset();
    // directed: back-to-back, minimum latency
    for (int k = 0; k < 8; k++) beats[k] = 32'hA0 + k;
    refill(32'h0000_1234, 0, 8'h00, -1, -1, -1, 1'b0, '0);
    // request stall of 3 and gaps after beats 2 and 5
    rand_beats();
    refill(32'h0000_1234, 3, 8'b0100_1000, -1, -1, -1, 1'b0, '0);
    // flush during RECV
    rand_beats();
    refill(32'hDEAD_BEE8, 1, 8'h00, 3, -1, -1, 1'b0, '0);
    // reset after beat 4, then a clean refill
    rand_beats();
    refill(32'h1357_9BDC, 0, 8'h00, -1, -1, 4, 1'b0, '0);
    rand_beats();
    refill(32'h1357_9BDC, 0, 8'h04, -1, -1, -1, 1'b0, '0);
    // early rlast on beat 3: sticky until reset
    rand_beats();
    refill(32'h0040_0010, 0, 8'h00, -1, 3, -1, 1'b0, '0);
    rand_beats();
    refill(32'h0040_0FFC, 2, 8'h00, -1, -1, -1, 1'b0, '0);
    do_reset();
    // missing rlast on beat 7
    rand_beats();
    refill(32'h0000_0000, 0, 8'h00, -1, 7, -1, 1'b0, '0);
    do_reset();
    // second miss held during a refill
    rand_beats();
    refill(32'hCAFE_0004, 1, 8'h10, -1, -1, -1, 1'b1, 32'h0BAD_F01C);
    rand_beats();
    refill(32'h0BAD_F01C, 0, 8'h00, -1, -1, -1, 1'b0, '0);
    // random traffic
    for (int t = 0; t < 20; t++) begin
      rand_beats();
      refill($urandom, int'($urandom_range(0, 3)), 8'($urandom & $urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1,
             -1, 1'b0, '0);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 256'(sb.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before 1000000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/icache_refill_unit.md
Name: icache_refill_unit

Overview:
- Miss-refill stage directly upstream of the icache data-bank and tag/valid RAMs.
- Accepts a miss address from the icache lookup FSM and issues a line-aligned burst read to the memory bus.
- Collects 8 incoming 32-bit beats into a 256-bit line buffer, then writes the full line into the data banks and {valid, tag} into the tag RAM in one cycle.
- Returns the requested instruction word to the CPU in that same cycle.

Parameters:
- INDEX_SIZE, 8, set-index width; RAM write-address width.
- TAG_SIZE, 20, tag width stored in the tag/valid entry.
- BANK_NUM, 8, 32-bit words per line; equals beats per burst.
- BANK_SIZE, 32, word and beat width.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- miss_valid  in  1  lookup FSM presents a miss.
- miss_addr  in  32  missing instruction address.
- miss_ready  out  1  high only in IDLE; a miss is accepted when miss_valid and miss_ready are both high.
- cpu_cancel  in  1  suppresses delivery of the pending instruction (pipeline flush).
- mem_req_valid  out  1  burst read request.
- mem_req_addr  out  32  {miss_addr[31:5], 5'b0}.
- mem_req_ready  in  1  bus accepts request.
- mem_rvalid  in  1  beat valid.
- mem_rdata  in  32  beat data.
- mem_rlast  in  1  bus marks final beat.
- ram_we  out  BANK_NUM  per-bank data write enable.
- ram_waddr  out  INDEX_SIZE  set index.
- ram_wdata  out  BANK_NUM*BANK_SIZE  line; word k at bits [32k+31:32k].
- tagv_we  out  1  tag/valid write enable.
- tagv_wdata  out  32  {valid=1, tag, zero padding in LSBs}.
- cpu_inst_valid  out  1  one-cycle pulse.
- cpu_inst  out  32  requested word.
- refill_busy  out  1  high in any state other than IDLE.
- protocol_err  out  1  sticky; cleared only by reset.

Behaviour:
- States: IDLE, REQ, RECV, WRITE.
- Reset (synchronous):
  - State goes to IDLE; beat counter, cancel flag and protocol_err clear to 0.
  - All outputs 0, except miss_ready = 1.
  - A reset in any state aborts the refill: no RAM or tag write, no cpu_inst_valid.
- IDLE:
  - On accept, latch the line address, index = miss_addr[11:4], tag = miss_addr[31:12], word = miss_addr[4:2].
  - Go to REQ.
- REQ:
  - mem_req_valid held high, mem_req_addr stable, until mem_req_ready.
  - Then go to RECV with beat counter = 0.
- RECV:
  - Each cycle with mem_rvalid high stores mem_rdata into buffer[counter] and increments the counter.
  - Beats arrive in incrementing order from word 0.
  - After the 8th beat, go to WRITE.
  - mem_rlast is checked, not used for sequencing: rlast high on beats 0–6, or low on beat 7, sets protocol_err. The FSM still relies on the counter.
  - Gaps (mem_rvalid low) are allowed and do not advance the counter.
- WRITE (exactly 1 cycle):
  - ram_we = all ones, ram_waddr = latched index, ram_wdata = buffer.
  - tagv_we = 1, tagv_wdata = {1'b1, tag, 11'b0}.
  - cpu_inst = buffer[word].
  - cpu_inst_valid = 1 unless the cancel flag is set.
  - Next state is IDLE.
- cpu_cancel:
  - Sampled in REQ, RECV and WRITE; sets a cancel flag.
  - The RAM/tag write still occurs; only cpu_inst_valid is suppressed.
  - The flag clears on return to IDLE.
- Latency from miss accept to cpu_inst_valid = 1 (REQ entry) + request wait + beat cycles + 1 (WRITE).
  - Minimum: accept at cycle 0, request accepted cycle 1, beats cycles 2–9, WRITE cycle 10.
- Outputs other than those listed per state are 0.
- mem_rvalid in IDLE, REQ or WRITE is ignored.
- miss_valid while busy is not accepted (miss_ready = 0).
- A new miss can be accepted in the cycle after WRITE.

Decomposition:
- Shared package (existing icache defines):
  - INDEX_SIZE, TAG_SIZE, BANK_NUM, BANK_SIZE.
  - Field-location constants for tag, index and word select.
  - State encoding as one-hot 4-bit: IDLE 0001, REQ 0010, RECV 0100, WRITE 1000.
- One sub-module: icache_line_buffer.
  - 8×32 register file with beat-counter write and word-select read.
  - Exposes the full 256-bit line.

Test Plan:
1. Miss at 0x0000_1234, request accepted immediately, 8 back-to-back beats 0xA0..0xA7 with rlast on the 8th -> mem_req_addr = 0x0000_1220; in WRITE: ram_waddr = 0x23, ram_we = 0xFF, tagv_wdata = {1, 20'h00001, 11'b0}, cpu_inst = 0xA5, cpu_inst_valid pulses at cycle 10; protocol_err = 0.
2. Same miss, mem_req_ready withheld 3 cycles and mem_rvalid gaps after beats 2 and 5 -> mem_req_addr stable while waiting; buffer words exact; cpu_inst_valid delayed by exactly 3 + 2 cycles.
3. cpu_cancel pulsed in RECV -> RAM and tag writes still occur with correct data; cpu_inst_valid stays 0; miss_ready returns to 1 the next cycle.
4. reset asserted after beat 4 -> next cycle IDLE with miss_ready = 1; no ram_we, tagv_we or cpu_inst_valid; a following miss completes normally.
5. mem_rlast asserted on beat 3 -> protocol_err goes high and stays high; refill still completes after 8 beats; protocol_err clears only on reset.
6. miss_valid held high throughout a refill with a second address -> not accepted until the cycle after WRITE; the second refill then uses the second address.
